// File: rtl/hacd_pkg.sv
// HACD shared types: AXI read packets, response codes, responder FSM states.
`ifndef HACD_AXI4_DATA_WIDTH
`define HACD_AXI4_DATA_WIDTH 512
`endif

package hacd_pkg;

    localparam int AXI_ADDR_W = 64;
    localparam int AXI_DATA_W = `HACD_AXI4_DATA_WIDTH;

    localparam logic [AXI_ADDR_W-1:0] HAWK_ATT_START = 64'h0000_0001_0000_0000;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        RESP = 2'd2
    } rdresp_state_t;

    typedef struct packed {
        logic [AXI_ADDR_W-1:0] addr;
        logic [7:0]            arlen;
        logic                  arvalid;
        logic                  rready;
    } axi_rd_reqpkt_t;

    typedef struct packed {
        logic arready;
    } axi_rd_rdypkt_t;

    typedef struct packed {
        logic                  rvalid;
        logic                  rlast;
        logic [AXI_DATA_W-1:0] rdata;
        logic [1:0]            rresp;
    } axi_rd_resppkt_t;

endpackage

// File: rtl/hawk_tbl_sram.sv
// HAWK table SRAM: one registered read port, one write port.
// A read and write to the same word on one edge returns the old word.
module hawk_tbl_sram #(
    parameter int DATA_WIDTH = 512,
    parameter int DEPTH_LOG2 = 12
) (
    input  logic                  clk_i,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] widx,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [DEPTH_LOG2-1:0] ridx,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clk_i) begin
        if (we) begin
            mem[widx] <= wdata;
        end
        if (re) begin
            rdata <= mem[ridx];
        end
    end

endmodule

// File: rtl/hawk_axi_rd_resp.sv
// AXI4 INCR read responder for HAWK table reads out of a local SRAM.
// One burst at a time, one beat every two cycles; out-of-window beats SLVERR.
`ifndef HACD_AXI4_DATA_WIDTH
`define HACD_AXI4_DATA_WIDTH 512
`endif

module hawk_axi_rd_resp
    import hacd_pkg::*;
#(
    parameter logic [AXI_ADDR_W-1:0] BASE_ADDR = HAWK_ATT_START,
    parameter int DEPTH_LOG2 = 12,
    parameter int DATA_WIDTH = `HACD_AXI4_DATA_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  axi_rd_reqpkt_t        rd_reqpkt,
    output axi_rd_rdypkt_t        rd_rdypkt,
    output axi_rd_resppkt_t       rd_resppkt,
    input  logic                  init_we,
    input  logic [DEPTH_LOG2-1:0] init_idx,
    input  logic [DATA_WIDTH-1:0] init_wdata,
    output logic                  busy
);

    localparam int SHIFT = $clog2(DATA_WIDTH / 8);
    localparam logic [DEPTH_LOG2:0] IDX_ONE = 1;

    rdresp_state_t         state;
    logic [DEPTH_LOG2:0]   idx;
    logic [7:0]            beats_left;
    logic                  err_q;
    logic                  arready_q;
    logic                  rvalid_q;
    logic                  rlast_q;
    logic                  ok_q;
    logic [1:0]            rresp_q;
    logic [DATA_WIDTH-1:0] sram_q;

    logic [AXI_ADDR_W-1:0] offset;
    logic [AXI_ADDR_W-1:0] word;
    logic                  below;
    logic                  above;
    logic                  beat_ok;
    logic                  sram_re;

    assign offset  = rd_reqpkt.addr - BASE_ADDR;
    assign word    = offset >> SHIFT;
    assign below   = rd_reqpkt.addr < BASE_ADDR;
    assign above   = (word >> DEPTH_LOG2) != '0;
    // idx MSB marks "ran off the end"; err_q covers a bad start address
    assign beat_ok = !err_q && !idx[DEPTH_LOG2];
    assign sram_re = (state == RD) && beat_ok;

    hawk_tbl_sram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_sram (
        .clk_i (clk_i),
        .we    (init_we),
        .widx  (init_idx),
        .wdata (init_wdata),
        .re    (sram_re),
        .ridx  (idx[DEPTH_LOG2-1:0]),
        .rdata (sram_q)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            idx        <= '0;
            beats_left <= '0;
            err_q      <= 1'b0;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rlast_q    <= 1'b0;
            ok_q       <= 1'b0;
            rresp_q    <= AXI_RESP_OKAY;
        end else begin
            unique case (state)
                IDLE: begin
                    arready_q <= 1'b1;
                    if (rd_reqpkt.arvalid && arready_q) begin
                        arready_q  <= 1'b0;
                        beats_left <= rd_reqpkt.arlen;
                        err_q      <= below || above;
                        idx        <= (below || above) ? '0 : word[DEPTH_LOG2:0];
                        state      <= RD;
                    end
                end
                RD: begin
                    rvalid_q <= 1'b1;
                    rlast_q  <= (beats_left == 8'd0);
                    ok_q     <= beat_ok;
                    rresp_q  <= beat_ok ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
                    state    <= RESP;
                end
                RESP: begin
                    if (rd_reqpkt.rready) begin
                        rvalid_q <= 1'b0;
                        rlast_q  <= 1'b0;
                        ok_q     <= 1'b0;
                        rresp_q  <= AXI_RESP_OKAY;
                        if (rlast_q) begin
                            arready_q <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            beats_left <= beats_left - 8'd1;
                            idx        <= idx + IDX_ONE;
                            state      <= RD;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign rd_rdypkt.arready = arready_q;
    assign rd_resppkt.rvalid = rvalid_q;
    assign rd_resppkt.rlast  = rlast_q;
    assign rd_resppkt.rresp  = rresp_q;
    assign rd_resppkt.rdata  = ok_q ? sram_q : '0;
    assign busy              = (state != IDLE);

endmodule

// File: tb/tb_hawk_axi_rd_resp.sv
// Bench for hawk_axi_rd_resp: directed corner sequences, a vector table
// and randomized bursts checked against a word-array reference model.
module tb_hawk_axi_rd_resp;
    import hacd_pkg::*;

    localparam int DL = 12;
    localparam int NW = 1 << DL;
    localparam int DW = 512;
    localparam logic [63:0] BASE = HAWK_ATT_START;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    axi_rd_reqpkt_t  req;
    axi_rd_rdypkt_t  rdy;
    axi_rd_resppkt_t resp;
    logic            init_we;
    logic [DL-1:0]   init_idx;
    logic [DW-1:0]   init_wdata;
    logic            busy;

    hawk_axi_rd_resp dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .rd_reqpkt  (req),
        .rd_rdypkt  (rdy),
        .rd_resppkt (resp),
        .init_we    (init_we),
        .init_idx   (init_idx),
        .init_wdata (init_wdata),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    logic [DW-1:0] mem_m [NW];

    int            hs_cyc;
    int            nb;
    logic [DW-1:0] bd [$];
    logic [1:0]    br [$];
    logic          bl [$];
    int            bv_cyc [$];
    int            ba_cyc [$];

    typedef struct {
        longint woff;
        int     bo;
        int     arlen;
        int     sb;
        int     sn;
        int     eok;
        int     eerr;
    } vec_t;

    vec_t vt [7];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] rnd512();
        logic [DW-1:0] v;
        for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic wr(input int idx, input logic [DW-1:0] d);
        init_we    = 1'b1;
        init_idx   = idx[DL-1:0];
        init_wdata = d;
        step();
        init_we    = 1'b0;
        mem_m[idx] = d;
    endtask

    // Word-level view: beat k of a burst reads word (addr-BASE)/64 + k.
    task automatic model(input logic [63:0] addr, input int k,
                         output logic [DW-1:0] d, output logic [1:0] r);
        logic [63:0] w;
        d = '0;
        r = AXI_RESP_SLVERR;
        if (addr >= BASE) begin
            w = (addr - BASE) / 64 + 64'(k);
            if (w < 64'(NW)) begin
                d = mem_m[w[DL-1:0]];
                r = AXI_RESP_OKAY;
            end
        end
    endtask

    task automatic burst(input logic [63:0] addr, input int arlen,
                         input int sb, input int sn);
        int budget, held;
        bit seen, done;
        logic [DW-1:0] hd;
        logic hl;
        logic [1:0] hr;
        bd.delete(); br.delete(); bl.delete();
        bv_cyc.delete(); ba_cyc.delete();
        nb = 0;
        req.addr = addr;
        req.arlen = 8'(arlen);
        req.arvalid = 1'b1;
        req.rready = 1'b1;
        budget = 0;
        while (!rdy.arready && budget < 50) begin
            step();
            budget++;
        end
        chk("ar.accept", rdy.arready, 1);
        hs_cyc = cyc;
        step();
        req.arvalid = 1'b0;
        chk("busy.rd", busy, 1);
        held = 0; seen = 0; done = 0; budget = 0;
        hd = '0; hl = 1'b0; hr = 2'b00;
        while (!done && budget < 600) begin
            if (resp.rvalid) begin
                if (!seen) begin
                    seen = 1;
                    hd = resp.rdata; hl = resp.rlast; hr = resp.rresp;
                    bv_cyc.push_back(cyc);
                end else begin
                    chk("hold.data", resp.rdata, hd);
                    chk("hold.last", resp.rlast, hl);
                    chk("hold.resp", resp.rresp, hr);
                end
                if (nb == sb && held < sn) begin
                    req.rready = 1'b0;
                    held++;
                end else begin
                    req.rready = 1'b1;
                    bd.push_back(resp.rdata);
                    br.push_back(resp.rresp);
                    bl.push_back(resp.rlast);
                    ba_cyc.push_back(cyc);
                    nb++;
                    held = 0;
                    seen = 0;
                    done = resp.rlast;
                end
            end
            step();
            budget++;
        end
        req.rready = 1'b1;
        chk("burst.done", done, 1);
        if (done) begin
            chk("ar.after_last", rdy.arready, 1);
            chk("rvalid.after_last", resp.rvalid, 0);
            chk("busy.after_last", busy, 0);
        end
    endtask

    task automatic verify(input string nm, input logic [63:0] addr, input int arlen);
        logic [DW-1:0] ed;
        logic [1:0] er;
        chk({nm, ".beats"}, nb, arlen + 1);
        for (int k = 0; k < nb && k <= arlen; k++) begin
            model(addr, k, ed, er);
            chk($sformatf("%s.data%0d", nm, k), bd[k], ed);
            chk($sformatf("%s.resp%0d", nm, k), br[k], er);
            chk($sformatf("%s.last%0d", nm, k), bl[k], k == arlen);
            if (k == 0)
                chk($sformatf("%s.lat%0d", nm, k), bv_cyc[0], hs_cyc + 2);
            else
                chk($sformatf("%s.lat%0d", nm, k), bv_cyc[k], ba_cyc[k-1] + 2);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] pat, oldv, newv;
        logic [63:0] addr;
        longint woff;
        int arlen, sb, sn, nok, budget;

        req = '0;
        req.rready = 1'b1;
        init_we = 1'b0;
        init_idx = '0;
        init_wdata = '0;

        vt[0] = '{5,    0,  0, -1, 0, 1,  0};
        vt[1] = '{0,    17, 7, 3,  2, 8,  0};
        vt[2] = '{4094, 3,  3, -1, 0, 2,  2};
        vt[3] = '{4095, 0,  0, 0,  3, 1,  0};
        vt[4] = '{4096, 0,  1, -1, 0, 0,  2};
        vt[5] = '{-1,   63, 2, 1,  1, 0,  3};
        vt[6] = '{100,  0,  15, 9, 4, 16, 0};

        rst = 1'b1;
        step();
        step();
        chk("rst.arready", rdy.arready, 0);
        chk("rst.rvalid", resp.rvalid, 0);
        chk("rst.rlast", resp.rlast, 0);
        chk("rst.rdata", resp.rdata, 0);
        chk("rst.rresp", resp.rresp, 0);
        chk("rst.busy", busy, 0);
        rst = 1'b0;
        step();
        chk("rel.arready", rdy.arready, 1);

        for (int i = 0; i < NW; i++) wr(i, rnd512());

        // Single beat, word 5
        pat = {64{8'hA5}};
        wr(5, pat);
        burst(BASE + 64'(5 * 64), 0, -1, 0);
        verify("t1", BASE + 64'(5 * 64), 0);
        if (nb > 0) chk("t1.pattern", bd[0], pat);
        step();
        chk("t1.arready_n4", rdy.arready, 1);

        // Four beats, rready high
        for (int i = 0; i < 4; i++) wr(i, DW'(i));
        burst(BASE, 3, -1, 0);
        verify("t2", BASE, 3);
        for (int k = 0; k < nb && k < 4; k++) begin
            chk($sformatf("t2.val%0d", k), bd[k], DW'(k));
            chk($sformatf("t2.cyc%0d", k), bv_cyc[k], hs_cyc + 2 + 2 * k);
        end

        // Same burst, beat 2 stalled five cycles
        burst(BASE, 3, 1, 5);
        verify("t3", BASE, 3);

        // Runs off the window end
        burst(BASE + 64'((NW - 1) * 64), 2, -1, 0);
        verify("t4", BASE + 64'((NW - 1) * 64), 2);
        if (nb == 3) begin
            chk("t4.r0", br[0], AXI_RESP_OKAY);
            chk("t4.r1", br[1], AXI_RESP_SLVERR);
            chk("t4.d2", bd[2], 0);
        end

        // Backdoor write colliding with the RD-state read of word 7
        oldv = rnd512();
        newv = ~oldv;
        wr(7, oldv);
        req.addr = BASE + 64'(7 * 64);
        req.arlen = 8'd0;
        req.arvalid = 1'b1;
        req.rready = 1'b1;
        budget = 0;
        while (!rdy.arready && budget < 50) begin step(); budget++; end
        chk("t5.ar", rdy.arready, 1);
        step();
        req.arvalid = 1'b0;
        init_we = 1'b1;
        init_idx = DL'(7);
        init_wdata = newv;
        step();
        init_we = 1'b0;
        mem_m[7] = newv;
        chk("t5.rvalid", resp.rvalid, 1);
        chk("t5.old", resp.rdata, oldv);
        chk("t5.last", resp.rlast, 1);
        step();
        chk("t5.arready", rdy.arready, 1);
        burst(BASE + 64'(7 * 64), 0, -1, 0);
        verify("t5b", BASE + 64'(7 * 64), 0);
        if (nb > 0) chk("t5.new", bd[0], newv);

        // Reset on beat 2 of a four-beat burst
        req.addr = BASE;
        req.arlen = 8'd3;
        req.arvalid = 1'b1;
        req.rready = 1'b1;
        budget = 0;
        while (!rdy.arready && budget < 50) begin step(); budget++; end
        step();
        req.arvalid = 1'b0;
        budget = 0;
        while (!resp.rvalid && budget < 20) begin step(); budget++; end
        chk("t6.beat1", resp.rvalid, 1);
        step();
        budget = 0;
        while (!resp.rvalid && budget < 20) begin step(); budget++; end
        chk("t6.beat2", resp.rvalid, 1);
        req.rready = 1'b0;
        rst = 1'b1;
        step();
        chk("t6.rst_rvalid", resp.rvalid, 0);
        chk("t6.rst_arready", rdy.arready, 0);
        chk("t6.rst_busy", busy, 0);
        step();
        chk("t6.rst_arready2", rdy.arready, 0);
        rst = 1'b0;
        req.rready = 1'b1;
        step();
        chk("t6.rel_arready", rdy.arready, 1);
        for (int i = 0; i < 8; i++) begin
            chk("t6.no_stray", resp.rvalid, 0);
            step();
        end
        burst(BASE + 64'(64), 1, -1, 0);
        verify("t6b", BASE + 64'(64), 1);

        // Vector table
        for (int v = 0; v < 7; v++) begin
            addr = BASE + 64'(vt[v].woff * 64 + longint'(vt[v].bo));
            burst(addr, vt[v].arlen, vt[v].sb, vt[v].sn);
            verify($sformatf("vec%0d", v), addr, vt[v].arlen);
            nok = 0;
            foreach (br[k]) if (br[k] == AXI_RESP_OKAY) nok++;
            chk($sformatf("vec%0d.nok", v), nok, vt[v].eok);
            chk($sformatf("vec%0d.nerr", v), nb - nok, vt[v].eerr);
        end

        // Randomized bursts
        for (int t = 0; t < 40; t++) begin
            for (int w = 0; w < int'($urandom_range(0, 2)); w++)
                wr(int'($urandom_range(0, NW - 1)), rnd512());
            case ($urandom_range(0, 9))
                0:       woff = -longint'($urandom_range(1, 3));
                1, 2:    woff = longint'($urandom_range(NW - 6, NW + 2));
                default: woff = longint'($urandom_range(0, NW - 1));
            endcase
            arlen = ($urandom_range(0, 4) == 0) ? int'($urandom_range(8, 20))
                                                : int'($urandom_range(0, 7));
            sb = int'($urandom_range(0, arlen));
            sn = int'($urandom_range(0, 3));
            addr = BASE + 64'(woff * 64 + longint'($urandom_range(0, 63)));
            burst(addr, arlen, sb, sn);
            verify($sformatf("rnd%0d", t), addr, arlen);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
